multi_ultrasonic_ranger: RTL and testbench
==========================================

MULTI_ULTRASONIC_RANGER -- requirements
Module: multi_ultrasonic_ranger

Interface
REQ-001 Parameter NUM_CH, default 2, number of ultrasonic channels scanned round-robin.
REQ-002 Parameter CNT_W, default 32, width of the range counter and range_cycles.
REQ-003 Parameter TRIG_CYCLES, default 1000, trigger pulse length in clk cycles (10 us at 100 MHz).
REQ-004 Parameter TIMEOUT_CYCLES, default 3_000_000, per-phase echo timeout (30 ms).
REQ-005 Parameter CRASH_CYCLES, default 294117, echo width at or below which a channel flags a crash.
REQ-006 Parameter HYST_CYCLES, default 29412, release hysteresis added to CRASH_CYCLES.
REQ-007 Parameter GAP_CYCLES, default 100_000, quiet time between channel pings (1 ms).
REQ-008 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 enable  input  1  scanning allowed while high.
REQ-011 echo  input  NUM_CH  raw asynchronous echo lines, one per channel.
REQ-012 trigger  output  NUM_CH  ranging trigger, one per channel, at most one bit high.
REQ-013 range_valid  output  1  one-cycle pulse, new measurement result.
REQ-014 range_ch  output  $clog2(NUM_CH) (min 1)  channel of current result.
REQ-015 range_cycles  output  CNT_W  echo high time in clk cycles; TIMEOUT_CYCLES on timeout.
REQ-016 range_timeout  output  1  result was a timeout, qualified by range_valid.
REQ-017 is_crash  output  NUM_CH  per-channel obstacle flag with hysteresis.
REQ-018 any_crash  output  1  OR of is_crash, registered, feeds the motor block.

Function
REQ-019 Each echo bit SHALL pass a 2-flop synchroniser; all decisions use synchronised echo (2-cycle input latency).
REQ-020 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, GAP; reset state IDLE, channel index 0.
REQ-021 IDLE: enable high -> TRIG next cycle; enable low -> stay.
REQ-022 TRIG: trigger[ch] high exactly TRIG_CYCLES cycles, then low and -> WAIT_RISE.
REQ-023 WAIT_RISE: only a synchronised 0->1 edge on echo[ch] enters MEASURE; an echo already high on entry SHALL NOT count as a rise; other channels' echo ignored.
REQ-024 WAIT_RISE lasting TIMEOUT_CYCLES cycles SHALL emit a timeout result and -> GAP.
REQ-025 MEASURE: counter starts at 1 on first high cycle, +1 per high cycle; on synchronised fall emit result = counter and -> GAP.
REQ-026 Counter reaching TIMEOUT_CYCLES in MEASURE SHALL emit timeout result (range_cycles = TIMEOUT_CYCLES) and -> GAP; counter never wraps.
REQ-027 Result: range_valid high one cycle, range_ch/range_cycles/range_timeout registered in that cycle and held until next result.
REQ-028 Crash update on result for channel ch: set if not timeout and range_cycles <= CRASH_CYCLES; clear if timeout or range_cycles > CRASH_CYCLES + HYST_CYCLES; otherwise hold.
REQ-029 is_crash and any_crash SHALL update the cycle after range_valid.
REQ-030 GAP: wait GAP_CYCLES cycles, advance ch to (ch+1) mod NUM_CH (NUM_CH-1 wraps to 0), -> IDLE.
REQ-031 enable low in TRIG/WAIT_RISE/MEASURE/GAP SHALL abort to IDLE next cycle: trigger low, no result, channel index and is_crash held; re-enable restarts at TRIG on the same channel.

Reset
REQ-032 rst_n low SHALL asynchronously clear trigger, range_valid, range_ch, range_cycles, range_timeout, is_crash, any_crash, counters, synchronisers, and force IDLE, channel 0.
REQ-033 Reset asserted mid-measurement SHALL drop trigger within the same cycle and discard the measurement.

Structure
REQ-034 FSM state enum and default timing constants SHALL live in shared package ranger_pkg.
REQ-035 The echo synchroniser SHALL be sub-module echo_sync (parameter WIDTH), instantiated once with WIDTH=NUM_CH.

Verification (bench params: NUM_CH=2, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, CRASH_CYCLES=20, HYST_CYCLES=5, GAP_CYCLES=3)
REQ-036 enable=1, echo[0] high 15 cycles after trigger -> trigger[0] high 4 cycles, range_valid with ch=0, cycles=15, timeout=0, is_crash[0]=1, any_crash=1.
REQ-037 Ch0 echo widths 15, then 23, then 26 -> is_crash[0] 1, held 1, then 0.
REQ-038 No echo on ch1 -> range_valid after 100 WAIT_RISE cycles, ch=1, cycles=100, timeout=1, is_crash[1]=0.
REQ-039 Echo held high 150 cycles -> result cycles=100, timeout=1; then next ping on next channel; channel wraps 1->0.
REQ-040 enable dropped mid-MEASURE, then reasserted -> no range_valid, trigger low, restart TRIG on same channel.
REQ-041 rst_n pulsed low during TRIG -> trigger and all outputs 0 immediately; after release ping starts on channel 0.

Source files
------------

// File: rtl/ranger_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger: scan FSM states
// and default timing constants (100 MHz clock).
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } ranger_state_t;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_TRIG_CYCLES    = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 3_000_000;
  localparam int DEF_CRASH_CYCLES   = 294117;
  localparam int DEF_HYST_CYCLES    = 29412;
  localparam int DEF_GAP_CYCLES     = 100_000;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the raw, asynchronous echo lines.
module echo_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/multi_ultrasonic_ranger.sv
// Round-robin ultrasonic ranger: pings one channel at a time, measures echo
// width in clock cycles and keeps a per-channel crash flag with hysteresis.
module multi_ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CRASH_CYCLES   = DEF_CRASH_CYCLES,
  parameter int HYST_CYCLES    = DEF_HYST_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger,
  output logic              range_valid,
  output logic [CH_W-1:0]   range_ch,
  output logic [CNT_W-1:0]  range_cycles,
  output logic              range_timeout,
  output logic [NUM_CH-1:0] is_crash,
  output logic              any_crash
);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CRASH_LIM    = CNT_W'(CRASH_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_LIM  = CNT_W'(CRASH_CYCLES + HYST_CYCLES);
  localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_CH - 1);

  ranger_state_t     r_state;
  ranger_state_t     w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic [NUM_CH-1:0] w_echo_s;
  logic [NUM_CH-1:0] r_echo_prev;
  logic              w_echo_ch;
  logic              w_rise;

  logic              w_emit;
  logic              w_emit_timeout;
  logic [CNT_W-1:0]  w_emit_cycles;

  logic              r_range_valid;
  logic [CH_W-1:0]   r_range_ch;
  logic [CNT_W-1:0]  r_range_cycles;
  logic              r_range_timeout;
  logic [NUM_CH-1:0] r_is_crash;
  logic [NUM_CH-1:0] w_is_crash_nxt;
  logic              r_any_crash;
  logic [NUM_CH-1:0] w_trigger;

  echo_sync #(
    .WIDTH (NUM_CH)
  ) u_echo_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (echo),
    .o_sync  (w_echo_s)
  );

  // Edge detection against the previous synchronised sample, so an echo that
  // is already high when WAIT_RISE is entered never looks like a rise.
  assign w_echo_ch = w_echo_s[r_ch];
  assign w_rise    = w_echo_ch & ~r_echo_prev[r_ch];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ch_nxt       = r_ch;
    w_emit         = 1'b0;
    w_emit_timeout = 1'b0;
    w_emit_cycles  = r_cnt;

    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = TRIG;
          w_cnt_nxt   = '0;
        end
      end

      TRIG: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TRIG_LAST) begin
          w_state_nxt = WAIT_RISE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      WAIT_RISE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_emit         = 1'b1;
          w_emit_timeout = 1'b1;
          w_emit_cycles  = TIMEOUT_VAL;
          w_state_nxt    = GAP;
          w_cnt_nxt      = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // The rise cycle already counted as 1; the counter saturates at the
      // timeout value rather than wrapping.
      MEASURE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= TIMEOUT_VAL) begin
          w_emit         = 1'b1;
          w_emit_timeout = 1'b1;
          w_emit_cycles  = TIMEOUT_VAL;
          w_state_nxt    = GAP;
          w_cnt_nxt      = '0;
        end else if (!w_echo_ch) begin
          w_emit      = 1'b1;
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ch_nxt    = (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Crash flag follows the registered result, so it lands one cycle after
  // range_valid; between the two thresholds the previous decision is kept.
  always_comb begin
    w_is_crash_nxt = r_is_crash;
    if (r_range_valid) begin
      if (!r_range_timeout && (r_range_cycles <= CRASH_LIM)) begin
        w_is_crash_nxt[r_range_ch] = 1'b1;
      end else if (r_range_timeout || (r_range_cycles > RELEASE_LIM)) begin
        w_is_crash_nxt[r_range_ch] = 1'b0;
      end
    end
  end

  always_comb begin
    w_trigger = '0;
    if (r_state == TRIG) begin
      w_trigger[r_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_ch            <= '0;
      r_cnt           <= '0;
      r_echo_prev     <= '0;
      r_range_valid   <= 1'b0;
      r_range_ch      <= '0;
      r_range_cycles  <= '0;
      r_range_timeout <= 1'b0;
      r_is_crash      <= '0;
      r_any_crash     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ch          <= w_ch_nxt;
      r_cnt         <= w_cnt_nxt;
      r_echo_prev   <= w_echo_s;
      r_range_valid <= w_emit;
      if (w_emit) begin
        r_range_ch      <= r_ch;
        r_range_cycles  <= w_emit_cycles;
        r_range_timeout <= w_emit_timeout;
      end
      r_is_crash  <= w_is_crash_nxt;
      r_any_crash <= |w_is_crash_nxt;
    end
  end

  assign trigger       = w_trigger;
  assign range_valid   = r_range_valid;
  assign range_ch      = r_range_ch;
  assign range_cycles  = r_range_cycles;
  assign range_timeout = r_range_timeout;
  assign is_crash      = r_is_crash;
  assign any_crash     = r_any_crash;

endmodule

// File: tb/tb_multi_ultrasonic_ranger.sv
// Directed bench for multi_ultrasonic_ranger: a table of pings with
// hand-computed results plus abort and mid-trigger reset sequences.
module tb_multi_ultrasonic_ranger;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  echoDrv;
  logic [1:0]  trigger;
  logic        range_valid;
  logic [0:0]  range_ch;
  logic [31:0] range_cycles;
  logic        range_timeout;
  logic [1:0]  is_crash;
  logic        any_crash;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         expCh;
    int         width;
    bit         preHigh;
    bit         otherPulse;
    int         expCycles;
    bit         expTimeout;
    logic [1:0] expCrash;
    bit         expAny;
  } vec_t;

  vec_t vecs[12];

  multi_ultrasonic_ranger #(
    .NUM_CH         (2),
    .CNT_W          (32),
    .TRIG_CYCLES    (4),
    .TIMEOUT_CYCLES (100),
    .CRASH_CYCLES   (20),
    .HYST_CYCLES    (5),
    .GAP_CYCLES     (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .echo          (echoDrv),
    .trigger       (trigger),
    .range_valid   (range_valid),
    .range_ch      (range_ch),
    .range_cycles  (range_cycles),
    .range_timeout (range_timeout),
    .is_crash      (is_crash),
    .any_crash     (any_crash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic reportExpired(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=no-event required=event-within-bound", name);
  endtask

  // Waits for a trigger pulse, returns its vector and length; ends on the
  // first negedge where trigger is low again.
  task automatic waitTrigger(input bit preHigh, input int ch, output logic [1:0] vec,
                             output int len, output bit ok);
    int waitCnt = 0;
    ok  = 1'b0;
    len = 0;
    vec = '0;
    @(negedge clk);
    while (trigger == 2'b00 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (trigger == 2'b00) begin
      reportExpired("trig_start");
      return;
    end
    vec = trigger;
    if (preHigh) echoDrv[ch] = 1'b1;
    while (trigger != 2'b00 && len < 50) begin
      len++;
      @(negedge clk);
    end
    ok = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [1:0] vec;
    int         len;
    bit         ok;
    int         t     = 0;
    int         tv    = 0;
    int         start = v.preHigh ? 20 : 2;
    bit         seen  = 1'b0;
    bit         done  = 1'b0;
    bit         gotTo = 1'b0;
    waitTrigger(v.preHigh, v.expCh, vec, len, ok);
    if (!ok) return;
    checkOutput("trig_vec", 32'(vec), 32'(1 << v.expCh));
    checkOutput("trig_len", 32'(len), 32'd4);
    while (1) begin
      if (range_valid && !seen) begin
        seen  = 1'b1;
        tv    = t;
        gotTo = range_timeout;
        checkOutput("range_ch", 32'(range_ch), 32'(v.expCh));
        checkOutput("range_cycles", range_cycles, 32'(v.expCycles));
        checkOutput("range_timeout", 32'(range_timeout), 32'(v.expTimeout));
      end else if (seen && !done && t == tv + 1) begin
        checkOutput("valid_pulse", 32'(range_valid), 32'd0);
        checkOutput("is_crash", 32'(is_crash), 32'(v.expCrash));
        checkOutput("any_crash", 32'(any_crash), 32'(v.expAny));
        done = 1'b1;
      end
      if (v.preHigh)
        echoDrv[v.expCh] = (t < 10) || (t >= start && t < start + v.width);
      else
        echoDrv[v.expCh] = (t >= start && t < start + v.width);
      echoDrv[1 - v.expCh] = v.otherPulse && (t >= 2) && (t < 8);
      if (done && (t >= start + v.width || gotTo)) break;
      if (t >= 400) begin
        reportExpired("range_valid_wait");
        break;
      end
      @(negedge clk);
      t++;
    end
    echoDrv = '0;
  endtask

  initial begin
    logic [1:0] vec;
    int         len;
    bit         ok;
    bit         sawValid;
    bit         sawTrig;
    int         waitCnt;

    vecs[0]  = '{0, 15,  0, 0, 15,  0, 2'b01, 1};
    vecs[1]  = '{1, 0,   0, 0, 100, 1, 2'b01, 1};
    vecs[2]  = '{0, 23,  0, 0, 23,  0, 2'b01, 1};
    vecs[3]  = '{1, 30,  0, 0, 30,  0, 2'b01, 1};
    vecs[4]  = '{0, 26,  0, 0, 26,  0, 2'b00, 0};
    vecs[5]  = '{1, 150, 0, 0, 100, 1, 2'b00, 0};
    vecs[6]  = '{0, 20,  0, 0, 20,  0, 2'b01, 1};
    vecs[7]  = '{1, 21,  1, 0, 21,  0, 2'b01, 1};
    vecs[8]  = '{0, 25,  0, 0, 25,  0, 2'b01, 1};
    vecs[9]  = '{1, 1,   0, 0, 1,   0, 2'b11, 1};
    vecs[10] = '{0, 0,   0, 1, 100, 1, 2'b10, 1};
    vecs[11] = '{1, 99,  0, 0, 99,  0, 2'b00, 0};

    rst_n   = 1'b0;
    enable  = 1'b0;
    echoDrv = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_trigger", 32'(trigger), 32'd0);
    checkOutput("rst_valid", 32'(range_valid), 32'd0);
    checkOutput("rst_cycles", range_cycles, 32'd0);
    checkOutput("rst_crash", 32'(is_crash), 32'd0);
    checkOutput("rst_any", 32'(any_crash), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_no_trigger", 32'(trigger), 32'd0);

    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
    end

    // Abort during MEASURE on channel 0, then restart on the same channel.
    waitTrigger(1'b0, 0, vec, len, ok);
    if (ok) begin
      checkOutput("abort_trig_vec", 32'(vec), 32'd1);
      for (int t = 0; t < 8; t++) begin
        echoDrv[0] = (t >= 2);
        @(negedge clk);
      end
      enable   = 1'b0;
      sawValid = 1'b0;
      sawTrig  = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (range_valid) sawValid = 1'b1;
        if (trigger != 2'b00) sawTrig = 1'b1;
        if (t == 10) echoDrv = '0;
      end
      checkOutput("abort_no_valid", 32'(sawValid), 32'd0);
      checkOutput("abort_no_trigger", 32'(sawTrig), 32'd0);
      checkOutput("abort_crash_held", 32'(is_crash), 32'd0);
      enable = 1'b1;
      applyStimulus('{0, 18, 0, 0, 18, 0, 2'b01, 1});
    end

    // Reset in the middle of the channel 1 trigger pulse.
    waitCnt = 0;
    @(negedge clk);
    while (trigger == 2'b00 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (trigger == 2'b00) begin
      reportExpired("reset_trig_start");
    end else begin
      @(negedge clk);
      checkOutput("pre_reset_trig", 32'(trigger), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_trigger", 32'(trigger), 32'd0);
      checkOutput("async_rst_valid", 32'(range_valid), 32'd0);
      checkOutput("async_rst_ch", 32'(range_ch), 32'd0);
      checkOutput("async_rst_cycles", range_cycles, 32'd0);
      checkOutput("async_rst_timeout", 32'(range_timeout), 32'd0);
      checkOutput("async_rst_crash", 32'(is_crash), 32'd0);
      checkOutput("async_rst_any", 32'(any_crash), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus('{0, 10, 0, 0, 10, 0, 2'b01, 1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
